// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x WIDTH register file with two write ports and two
// combinational read ports, plus a per-register scoreboard of pending writes.
module regfile_sb #(
    parameter int unsigned  WIDTH  = 16,
    parameter int unsigned  DEPTH  = 8,
    parameter bit           BYPASS = 1'b1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WE0,
    input  logic [AW-1:0]    WA0,
    input  logic [WIDTH-1:0] WD0,
    input  logic             WE1,
    input  logic [AW-1:0]    WA1,
    input  logic [WIDTH-1:0] WD1,
    input  logic [AW-1:0]    SR1,
    input  logic [AW-1:0]    SR2,
    output logic [WIDTH-1:0] SR1_OUT,
    output logic [WIDTH-1:0] SR2_OUT,
    output logic             SR1_Busy,
    output logic             SR2_Busy,
    input  logic             Res_En,
    input  logic [AW-1:0]    Res_Addr,
    output logic             Res_Grant,
    input  logic             Flush,
    output logic [AW:0]      Busy_Count
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      busy_count;
    logic [AW:0]      count_nxt;
    logic             grant;

    logic             hit0_a;
    logic             hit1_a;
    logic             hit0_b;
    logic             hit1_b;

    // A write landing on Res_Addr this cycle does not free it for the reserve.
    assign grant     = Res_En & ~busy[Res_Addr] & ~Flush;
    assign Res_Grant = grant;

    // Order matters: writes clear, then a grant sets (reserve wins), then Flush clears all.
    always_comb begin
        busy_nxt = busy;
        if (WE0) busy_nxt[WA0] = 1'b0;
        if (WE1) busy_nxt[WA1] = 1'b0;
        if (grant) busy_nxt[Res_Addr] = 1'b1;
        if (Flush) busy_nxt = '0;
    end

    always_comb begin
        count_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_nxt = count_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (WE0) regs[WA0] <= WD0;
            // Port 1 assigned last so it wins an address collision.
            if (WE1) regs[WA1] <= WD1;
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    always_comb begin
        hit0_a = BYPASS && WE0 && (WA0 == SR1);
        hit1_a = BYPASS && WE1 && (WA1 == SR1);
        hit0_b = BYPASS && WE0 && (WA0 == SR2);
        hit1_b = BYPASS && WE1 && (WA1 == SR2);
    end

    always_comb begin
        SR1_OUT = regs[SR1];
        if (hit1_a)      SR1_OUT = WD1;
        else if (hit0_a) SR1_OUT = WD0;
    end

    always_comb begin
        SR2_OUT = regs[SR2];
        if (hit1_b)      SR2_OUT = WD1;
        else if (hit0_b) SR2_OUT = WD0;
    end

    assign SR1_Busy   = busy[SR1] & ~(hit0_a | hit1_a);
    assign SR2_Busy   = busy[SR2] & ~(hit0_b | hit1_b);
    assign Busy_Count = busy_count;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal checks, plus a per-cycle
// comparison against an array/scoreboard model of the register file.
module tb_regfile_sb;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          Clk;
    logic          Reset;
    logic          WE0;
    logic [AW-1:0] WA0;
    logic [W-1:0]  WD0;
    logic          WE1;
    logic [AW-1:0] WA1;
    logic [W-1:0]  WD1;
    logic [AW-1:0] SR1;
    logic [AW-1:0] SR2;
    logic [W-1:0]  SR1_OUT;
    logic [W-1:0]  SR2_OUT;
    logic          SR1_Busy;
    logic          SR2_Busy;
    logic          Res_En;
    logic [AW-1:0] Res_Addr;
    logic          Res_Grant;
    logic          Flush;
    logic [AW:0]   Busy_Count;

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1)) dut (
        .Clk(Clk), .Reset(Reset),
        .WE0(WE0), .WA0(WA0), .WD0(WD0),
        .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .SR1(SR1), .SR2(SR2),
        .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT),
        .SR1_Busy(SR1_Busy), .SR2_Busy(SR2_Busy),
        .Res_En(Res_En), .Res_Addr(Res_Addr), .Res_Grant(Res_Grant),
        .Flush(Flush), .Busy_Count(Busy_Count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: plain arrays of register contents and pending flags.
    logic [W-1:0] m_reg [D];
    bit           m_busy [D];
    bit           model_valid = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
        if (WE1 && WA1 == a) return WD1;
        if (WE0 && WA0 == a) return WD0;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if ((WE0 && WA0 == a) || (WE1 && WA1 == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int busy_total();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Model state update, from the inputs held across the rising edge.
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < D; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            model_valid = 1;
        end else begin
            bit g;
            g = Res_En && !m_busy[Res_Addr] && !Flush;
            if (WE0) begin m_reg[WA0] = WD0; m_busy[WA0] = 1'b0; end
            if (WE1) begin m_reg[WA1] = WD1; m_busy[WA1] = 1'b0; end
            if (g) m_busy[Res_Addr] = 1'b1;
            if (Flush) for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
        end
    end

    // Per-cycle compare, mid-cycle while inputs are stable.
    always @(negedge Clk) begin
        if (model_valid) begin
            chk("m_sr1_out",  SR1_OUT,    exp_read(SR1));
            chk("m_sr2_out",  SR2_OUT,    exp_read(SR2));
            chk("m_sr1_busy", SR1_Busy,   exp_busy(SR1));
            chk("m_sr2_busy", SR2_Busy,   exp_busy(SR2));
            chk("m_grant",    Res_Grant,  Res_En && !m_busy[Res_Addr] && !Flush);
            chk("m_count",    Busy_Count, busy_total());
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        Reset = 1'b0; WE0 = 1'b0; WE1 = 1'b0; Res_En = 1'b0; Flush = 1'b0;
    endtask

    initial begin
        clr();
        Reset = 1'b1;
        WA0 = '0; WD0 = '0; WA1 = '0; WD1 = '0;
        SR1 = '0; SR2 = '0; Res_Addr = '0;
        tick(); tick();

        clr(); SR1 = 3'd0; SR2 = 3'd7; #1;
        chk("rst_sr1_out", SR1_OUT, 0);
        chk("rst_sr2_out", SR2_OUT, 0);
        chk("rst_sr1_busy", SR1_Busy, 0);
        chk("rst_count", Busy_Count, 0);
        Res_En = 1'b1; Res_Addr = 3'd0; #1;
        chk("rst_grant_follows_en", Res_Grant, 1);
        tick();
        clr(); Flush = 1'b1; tick();

        // single write then read-back
        clr(); WE0 = 1'b1; WA0 = 3'd3; WD0 = 16'h1234; tick();
        clr(); SR1 = 3'd3; SR2 = 3'd0; #1;
        chk("wr_rd_sr1", SR1_OUT, 16'h1234);
        chk("wr_rd_sr2_zero", SR2_OUT, 16'h0000);

        // write collision, port 1 wins, forwarded same cycle
        WE0 = 1'b1; WA0 = 3'd5; WD0 = 16'hAAAA;
        WE1 = 1'b1; WA1 = 3'd5; WD1 = 16'h5555; SR1 = 3'd5; #1;
        chk("collide_bypass", SR1_OUT, 16'h5555);
        tick();
        clr(); #1;
        chk("collide_stored", SR1_OUT, 16'h5555);

        // port 0 forwarding, distinct addresses
        WE0 = 1'b1; WA0 = 3'd1; WD0 = 16'h0101;
        WE1 = 1'b1; WA1 = 3'd4; WD1 = 16'h0404; SR1 = 3'd4; SR2 = 3'd1; #1;
        chk("bypass_p0", SR2_OUT, 16'h0101);
        chk("bypass_p1", SR1_OUT, 16'h0404);
        tick();

        // reserve, re-reserve refused, write clears
        clr(); Res_En = 1'b1; Res_Addr = 3'd2; #1;
        chk("res_grant", Res_Grant, 1);
        tick();
        clr(); SR1 = 3'd2; #1;
        chk("res_busy", SR1_Busy, 1);
        chk("res_count1", Busy_Count, 1);
        Res_En = 1'b1; Res_Addr = 3'd2; #1;
        chk("res_again_refused", Res_Grant, 0);
        tick();
        clr(); WE1 = 1'b1; WA1 = 3'd2; WD1 = 16'hBEEF; SR1 = 3'd2; #1;
        chk("wr_masks_busy", SR1_Busy, 0);
        chk("wr_bypass_busy_reg", SR1_OUT, 16'hBEEF);
        tick();
        clr(); #1;
        chk("wr_clears_count", Busy_Count, 0);

        // three reserves, then Flush overriding a reserve
        Res_En = 1'b1; Res_Addr = 3'd1; tick();
        Res_Addr = 3'd4; tick();
        Res_Addr = 3'd7; tick();
        clr(); #1;
        chk("three_res_count", Busy_Count, 3);
        Flush = 1'b1; Res_En = 1'b1; Res_Addr = 3'd0; #1;
        chk("flush_blocks_grant", Res_Grant, 0);
        tick();
        clr(); #1;
        chk("flush_count", Busy_Count, 0);

        // reserve vs write on register 6
        Res_En = 1'b1; Res_Addr = 3'd6; tick();
        clr(); Res_En = 1'b1; Res_Addr = 3'd6;
        WE0 = 1'b1; WA0 = 3'd6; WD0 = 16'h6666; SR1 = 3'd6; #1;
        chk("busy_write_no_grant", Res_Grant, 0);
        chk("busy_write_masked", SR1_Busy, 0);
        tick();
        clr(); #1;
        chk("busy6_cleared", SR1_Busy, 0);
        chk("busy6_count0", Busy_Count, 0);
        Res_En = 1'b1; Res_Addr = 3'd6; WE0 = 1'b1; WA0 = 3'd6; WD0 = 16'h7777; #1;
        chk("free_write_grant", Res_Grant, 1);
        tick();
        clr(); #1;
        chk("reserve_wins", SR1_Busy, 1);
        chk("reserve_wins_data", SR1_OUT, 16'h7777);
        chk("reserve_wins_count", Busy_Count, 1);

        // Reset mid-operation discards write and reserve
        Res_En = 1'b1; Res_Addr = 3'd3; tick();
        clr(); Reset = 1'b1; WE0 = 1'b1; WA0 = 3'd4; WD0 = 16'hFFFF;
        Res_En = 1'b1; Res_Addr = 3'd5; Flush = 1'b1; tick();
        clr(); #1;
        chk("reset_count", Busy_Count, 0);
        for (int a = 0; a < D; a++) begin
            logic [AW-1:0] ra;
            ra = AW'(a);
            SR1 = ra; SR2 = ~ra; #1;
            chk("reset_sr1_zero", SR1_OUT, 0);
            chk("reset_sr2_zero", SR2_OUT, 0);
            chk("reset_sr1_busy", SR1_Busy, 0);
            tick();
        end

        // random traffic, checked by the per-cycle model compare
        for (int n = 0; n < 60; n++) begin
            WE0 = 1'($urandom_range(0, 1)); WA0 = AW'($urandom_range(0, D - 1)); WD0 = W'($urandom);
            WE1 = 1'($urandom_range(0, 1)); WA1 = AW'($urandom_range(0, D - 1)); WD1 = W'($urandom);
            SR1 = AW'($urandom_range(0, D - 1)); SR2 = AW'($urandom_range(0, D - 1));
            Res_En = 1'($urandom_range(0, 1)); Res_Addr = AW'($urandom_range(0, D - 1));
            Flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        clr(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
